// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART receiver. The raw line is double-flopped, start bits are
//   detected on the synchronised line, data bits are sampled mid-bit LSB
//   first, and each good byte is presented in a one-deep valid/ready
//   output register. Framing errors and overruns produce one-cycle pulses.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   rx           raw serial line, idle high, asynchronous to clk
//   data_o       received byte, valid while valid_o is high
//   valid_o      output register holds a byte
//   ready_i      consumer accepts on valid_o && ready_i at a clock edge
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: good byte dropped, output register full
module uart_rx_byte #(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             rxs_q, rxs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         rxs_q   <= rxs_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      sync1_d = rx;
      rxs_d   = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      // Accept first; a load in the stop branch below overrides it so a
      // simultaneous consume+load keeps valid high with the new byte.
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rxs_q) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rxs_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rxs_q;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rxs_q) begin
                  // Back to IDLE on the stop sample so a following start
                  // bit is seen with no dead time.
                  state_d = ST_IDLE;
                  if (!valid_q || ready_i) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // A held-low line must go high before a new start is accepted.
            cnt_d = '0;
            if (rxs_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
   assign overrun_o   = ovr_q;

endmodule
